tls_monitor: RTL and testbench

//  Observer at the far end of the traffic-light interface: samples the G/Y/R lamp lines and the Set/Jump/Stop

---
 rtl/tls_pkg.sv | 25 ++
 rtl/tls_monitor_if.sv | 30 +++
 rtl/tls_lamp_decode.sv | 22 ++
 rtl/tls_monitor.sv | 155 +++++++++++++++
 tb/tb_tls_monitor.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/tls_pkg.sv
// Shared phase encoding and helpers for the traffic-light monitor.
package tls_pkg;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_RED    = 2'b11
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_GREEN:  next_phase = PH_YELLOW;
            PH_YELLOW: next_phase = PH_RED;
            PH_RED:    next_phase = PH_GREEN;
            default:   next_phase = PH_IDLE;
        endcase
    endfunction

    // A programmed duration of zero stands for the full 2**dw range.
    function automatic int unsigned exp_len(input int unsigned d, input int unsigned dw);
        exp_len = (d == 0) ? (32'd1 << dw) : d;
    endfunction

endpackage

// File: rtl/tls_monitor_if.sv
// Observation bundle between the light controller, its lamps and the monitor.
// No backpressure anywhere: inputs are sampled every clock, meas_valid and the err pulses are one-cycle strobes.
interface tls_monitor_if #(
    parameter int DW = 4,
    parameter int CW = 5
);
    logic          Set, Stop, Jump;
    logic [DW-1:0] Gin, Yin, Rin;
    logic          Gl, Yl, Rl;
    logic [1:0]    phase;
    logic          meas_valid;
    logic [1:0]    meas_phase;
    logic [CW-1:0] meas_len;
    logic          meas_forced;
    logic          seq_err, dur_err, ill_err;
    logic [7:0]    err_cnt;
    logic [1:0]    dbg_prev;

    modport master (
        output Set, Stop, Jump, Gin, Yin, Rin, Gl, Yl, Rl,
        input  phase, meas_valid, meas_phase, meas_len, meas_forced,
        input  seq_err, dur_err, ill_err, err_cnt, dbg_prev
    );

    modport slave (
        input  Set, Stop, Jump, Gin, Yin, Rin, Gl, Yl, Rl,
        output phase, meas_valid, meas_phase, meas_len, meas_forced,
        output seq_err, dur_err, ill_err, err_cnt, dbg_prev
    );
endinterface

// File: rtl/tls_lamp_decode.sv
// Combinational lamp decoder: exactly one lamp lit names the phase, more than one is illegal.
import tls_pkg::*;

module tls_lamp_decode (
    input  logic   i_g,
    input  logic   i_y,
    input  logic   i_r,
    output phase_t o_phase,
    output logic   o_ill
);
    always_comb begin
        o_phase = PH_IDLE;
        o_ill   = 1'b0;
        case ({i_g, i_y, i_r})
            3'b100:  o_phase = PH_GREEN;
            3'b010:  o_phase = PH_YELLOW;
            3'b001:  o_phase = PH_RED;
            3'b000:  o_phase = PH_IDLE;
            default: o_ill   = 1'b1;
        endcase
    end
endmodule

// File: rtl/tls_monitor.sv
// Traffic-light phase monitor: measures each lamp phase run and flags order, duration and pattern errors.
// Optional saturating error counter enabled by defining TLS_MON_ERRCNT_EN.
import tls_pkg::*;

module tls_monitor #(
    parameter int DW = 4,
    parameter int CW = 5
) (
    input logic          clk,
    input logic          reset,
    tls_monitor_if.slave mon
);
    phase_t        w_cur;
    logic          w_ill, w_abort;
    phase_t        r_prev, r_pend, w_prev_n, w_pend_n;
    logic [CW-1:0] r_run, w_run_n, w_run_inc;
    logic [DW-1:0] r_gd, r_yd, r_rd, w_dur_cfg;
    logic [CW-1:0] w_exp;
    logic          w_mv, w_mf, w_seq, w_dur;
    phase_t        w_mph;
    logic [CW-1:0] w_mlen;
    phase_t        r_phase, r_mph;
    logic          r_mv, r_mf, r_seq, r_dur, r_ill;
    logic [CW-1:0] r_mlen;

    tls_lamp_decode u_dec (
        .i_g     (mon.Gl),
        .i_y     (mon.Yl),
        .i_r     (mon.Rl),
        .o_phase (w_cur),
        .o_ill   (w_ill)
    );

    assign w_abort   = mon.Set | mon.Jump | w_ill;
    assign w_run_inc = (r_run == '1) ? r_run : r_run + {{(CW-1){1'b0}}, ~mon.Stop};

    always_comb begin
        case (r_prev)
            PH_GREEN:  w_dur_cfg = r_gd;
            PH_YELLOW: w_dur_cfg = r_yd;
            PH_RED:    w_dur_cfg = r_rd;
            default:   w_dur_cfg = '0;
        endcase
    end
    assign w_exp = CW'(exp_len(32'(w_dur_cfg), DW));

    // Next-state: abort beats phase change beats continuing the current run.
    always_comb begin
        w_prev_n = r_prev;
        w_pend_n = r_pend;
        w_run_n  = r_run;
        w_mv     = 1'b0;
        w_mf     = 1'b0;
        w_mph    = PH_IDLE;
        w_mlen   = '0;
        w_seq    = 1'b0;
        if (w_abort) begin
            if (r_prev != PH_IDLE) begin
                w_mv   = 1'b1;
                w_mf   = 1'b1;
                w_mph  = r_prev;
                w_mlen = (w_cur == r_prev) ? w_run_inc : r_run;
            end
            w_prev_n = PH_IDLE;
            w_run_n  = '0;
            if (mon.Set)       w_pend_n = PH_GREEN;
            else if (mon.Jump) w_pend_n = PH_RED;
        end else if (w_cur != r_prev && w_cur != PH_IDLE) begin
            if (r_prev != PH_IDLE) begin
                w_mv   = 1'b1;
                w_mph  = r_prev;
                w_mlen = r_run;
            end
            if (r_pend != PH_IDLE) begin
                w_seq    = (w_cur != r_pend);
                w_pend_n = PH_IDLE;
            end else if (r_prev != PH_IDLE) begin
                w_seq = (w_cur != next_phase(r_prev));
            end
            w_run_n  = {{(CW-1){1'b0}}, ~mon.Stop};
            w_prev_n = w_cur;
        end else if (w_cur == PH_IDLE && r_prev != PH_IDLE) begin
            w_mv     = 1'b1;
            w_mf     = 1'b1;
            w_mph    = r_prev;
            w_mlen   = r_run;
            w_prev_n = PH_IDLE;
            w_run_n  = '0;
        end else if (w_cur != PH_IDLE) begin
            w_run_n = w_run_inc;
        end
    end

    assign w_dur = w_mv & ~w_mf & (w_mlen != w_exp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev  <= PH_IDLE;
            r_pend  <= PH_IDLE;
            r_run   <= '0;
            r_gd    <= '0;
            r_yd    <= '0;
            r_rd    <= '0;
            r_phase <= PH_IDLE;
            r_mv    <= 1'b0;
            r_mph   <= PH_IDLE;
            r_mlen  <= '0;
            r_mf    <= 1'b0;
            r_seq   <= 1'b0;
            r_dur   <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_prev  <= w_prev_n;
            r_pend  <= w_pend_n;
            r_run   <= w_run_n;
            if (mon.Set) begin
                r_gd <= mon.Gin;
                r_yd <= mon.Yin;
                r_rd <= mon.Rin;
            end
            r_phase <= w_cur;
            r_mv    <= w_mv;
            r_mph   <= w_mph;
            r_mlen  <= w_mlen;
            r_mf    <= w_mf;
            r_seq   <= w_seq;
            r_dur   <= w_dur;
            r_ill   <= w_ill;
        end
    end

`ifdef TLS_MON_ERRCNT_EN
    logic [7:0] r_err_cnt;
    logic [9:0] w_sum;
    // Counts alongside the pulses it sums, so err_cnt and the pulses update on the same edge.
    assign w_sum = {2'b00, r_err_cnt} + {9'd0, w_seq} + {9'd0, w_dur} + {9'd0, w_ill};
    always_ff @(posedge clk) begin
        if (reset || mon.Set) r_err_cnt <= '0;
        else                  r_err_cnt <= (w_sum > 10'd255) ? 8'd255 : w_sum[7:0];
    end
    assign mon.err_cnt = r_err_cnt;
`else
    assign mon.err_cnt = '0;
`endif

    assign mon.phase       = r_phase;
    assign mon.meas_valid  = r_mv;
    assign mon.meas_phase  = r_mph;
    assign mon.meas_len    = r_mlen;
    assign mon.meas_forced = r_mf;
    assign mon.seq_err     = r_seq;
    assign mon.dur_err     = r_dur;
    assign mon.ill_err     = r_ill;
    assign mon.dbg_prev    = r_prev;
endmodule

// File: tb/tb_tls_monitor.sv
// Self-checking bench for tls_monitor: table of per-sample vectors plus error-counter sequences.
module tb_tls_monitor;
    localparam int DW = 4;
    localparam int CW = 5;
    localparam int PI = 0, PG = 1, PY = 2, PR = 3;
    localparam logic [2:0] C_N = 3'b000, C_SET = 3'b100, C_JMP = 3'b010, C_STP = 3'b001;
    localparam logic [2:0] L_0 = 3'b000, L_G = 3'b100, L_Y = 3'b010, L_R = 3'b001;
    localparam logic [2:0] L_GY = 3'b110, L_GYR = 3'b111;
`ifdef TLS_MON_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Expected record layout: {phase[2], valid, mphase[2], mlen[5], forced, seq, dur, ill}
    typedef struct {
        logic [2:0]  ctl;
        logic [2:0]  lamps;
        logic [11:0] durs;
        logic [13:0] exp_v;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];
    logic [13:0] exp_q[$];
    logic [11:0] d_cfg = '0;

    tls_monitor_if #(.DW(DW), .CW(CW)) mon ();
    tls_monitor #(.DW(DW), .CW(CW)) dut (.clk(clk), .reset(reset), .mon(mon));

    always #5 clk = ~clk;

    function automatic logic [13:0] ex(input int ph, v, mph, len, f, s, d, i);
        return {2'(ph), 1'(v), 2'(mph), 5'(len), 1'(f), 1'(s), 1'(d), 1'(i)};
    endfunction

    function automatic logic [13:0] q(input int ph);
        return ex(ph, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic add(input logic [2:0] ctl, input logic [2:0] lamps, input logic [13:0] e);
        vec_t t;
        t.ctl = ctl; t.lamps = lamps; t.durs = d_cfg; t.exp_v = e;
        tbl.push_back(t);
    endtask

    task automatic addn(input int n, input logic [2:0] ctl, input logic [2:0] lamps, input int ph);
        for (int k = 0; k < n; k++) add(ctl, lamps, q(ph));
    endtask

    task automatic step(input vec_t t, input int idx);
        logic [13:0] got, e, mask;
        mon.Set  = t.ctl[2];
        mon.Jump = t.ctl[1];
        mon.Stop = t.ctl[0];
        {mon.Gin, mon.Yin, mon.Rin} = t.durs;
        {mon.Gl, mon.Yl, mon.Rl} = t.lamps;
        exp_q.push_back(t.exp_v);
        @(posedge clk);
        #1;
        got = {mon.phase, mon.meas_valid, mon.meas_phase, mon.meas_len,
               mon.meas_forced, mon.seq_err, mon.dur_err, mon.ill_err};
        e = exp_q.pop_front();
        // Report fields carry no meaning unless a report is expected.
        mask = e[11] ? 14'h3fff : 14'b11_1_00_00000_0_111;
        n_cmp++;
        if ((got & mask) != (e & mask)) begin
            n_bad++;
            $display("FAIL vec%0d: got %b need %b (ph,v,mph,len,f,seq,dur,ill)", idx, got & mask, e & mask);
        end
    endtask

    task automatic chk_cnt(input logic [7:0] want, input int tag);
        n_cmp++;
        if (mon.err_cnt != want) begin
            n_bad++;
            $display("FAIL err_cnt#%0d: got %0d need %0d", tag, mon.err_cnt, want);
        end
    endtask

    task automatic one(input logic [2:0] ctl, input logic [2:0] lamps, input logic [13:0] e, input int idx);
        vec_t t;
        t.ctl = ctl; t.lamps = lamps; t.durs = d_cfg; t.exp_v = e;
        step(t, idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        {mon.Set, mon.Jump, mon.Stop} = 3'b000;
        {mon.Gin, mon.Yin, mon.Rin} = '0;
        {mon.Gl, mon.Yl, mon.Rl} = 3'b000;

        // Full cycle G3/Y2/R4
        d_cfg = {4'd3, 4'd2, 4'd4};
        add(C_SET, L_0, q(PI));
        addn(3, C_N, L_G, PG);
        add(C_N, L_Y, ex(PY, 1, PG, 3, 0, 0, 0, 0));
        add(C_N, L_Y, q(PY));
        add(C_N, L_R, ex(PR, 1, PY, 2, 0, 0, 0, 0));
        addn(3, C_N, L_R, PR);
        add(C_N, L_G, ex(PG, 1, PR, 4, 0, 0, 0, 0));
        // Stop-frozen samples are not counted; lamps going dark give a forced report
        addn(2, C_N, L_G, PG);
        addn(2, C_STP, L_G, PG);
        add(C_N, L_Y, ex(PY, 1, PG, 3, 0, 0, 0, 0));
        add(C_N, L_0, ex(PI, 1, PY, 1, 1, 0, 0, 0));
        // Zero duration means 16; 15 is short; 35 saturates at 31
        d_cfg = {4'd0, 4'd2, 4'd4};
        add(C_SET, L_0, q(PI));
        addn(16, C_N, L_G, PG);
        add(C_N, L_Y, ex(PY, 1, PG, 16, 0, 0, 0, 0));
        add(C_SET, L_Y, ex(PY, 1, PY, 2, 1, 0, 0, 0));
        addn(15, C_N, L_G, PG);
        add(C_N, L_Y, ex(PY, 1, PG, 15, 0, 0, 1, 0));
        add(C_SET, L_0, ex(PI, 1, PY, 1, 1, 0, 0, 0));
        addn(35, C_N, L_G, PG);
        add(C_N, L_Y, ex(PY, 1, PG, 31, 0, 0, 1, 0));
        // Jump handling, excused and unexcused transitions, Set beating Jump
        d_cfg = {4'd3, 4'd2, 4'd4};
        add(C_SET, L_0, ex(PI, 1, PY, 1, 1, 0, 0, 0));
        add(C_N, L_G, q(PG));
        add(C_JMP, L_G, ex(PG, 1, PG, 2, 1, 0, 0, 0));
        addn(4, C_N, L_R, PR);
        add(C_N, L_G, ex(PG, 1, PR, 4, 0, 0, 0, 0));
        add(C_JMP, L_G, ex(PG, 1, PG, 2, 1, 0, 0, 0));
        add(C_N, L_Y, ex(PY, 0, 0, 0, 0, 1, 0, 0));
        add(C_N, L_Y, q(PY));
        add(C_N, L_R, ex(PR, 1, PY, 2, 0, 0, 0, 0));
        add(C_SET | C_JMP, L_0, ex(PI, 1, PR, 1, 1, 0, 0, 0));
        add(C_N, L_R, ex(PR, 0, 0, 0, 0, 1, 0, 0));
        add(C_N, L_0, ex(PI, 1, PR, 1, 1, 0, 0, 0));
        // Illegal order and illegal lamp patterns
        add(C_SET, L_0, q(PI));
        addn(3, C_N, L_G, PG);
        add(C_N, L_R, ex(PR, 1, PG, 3, 0, 1, 0, 0));
        add(C_N, L_GY, ex(PI, 1, PR, 1, 1, 0, 0, 1));
        add(C_N, L_G, q(PG));
        add(C_N, L_GYR, ex(PI, 1, PG, 1, 1, 0, 0, 1));
        add(C_N, L_GY, ex(PI, 0, 0, 0, 0, 0, 0, 1));
        add(C_N, L_0, q(PI));
        // Abort on the same phase with Stop high: the aborting sample adds nothing
        addn(2, C_N, L_G, PG);
        add(C_JMP | C_STP, L_G, ex(PG, 1, PG, 2, 1, 0, 0, 0));
        add(C_N, L_0, q(PI));

        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({mon.phase, mon.meas_valid, mon.meas_phase, mon.meas_len, mon.meas_forced,
             mon.seq_err, mon.dur_err, mon.ill_err} != 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b need 0", {mon.phase, mon.meas_valid, mon.meas_phase,
                     mon.meas_len, mon.meas_forced, mon.seq_err, mon.dur_err, mon.ill_err});
        end
        chk_cnt(8'd0, 0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Error counter: 10 events, then saturation after 300, then cleared by Set
        d_cfg = {4'd3, 4'd2, 4'd4};
        one(C_SET, L_0, q(PI), 1000);
        for (int i = 0; i < 10; i++) one(C_N, L_GY, ex(PI, 0, 0, 0, 0, 0, 0, 1), 1001);
        one(C_N, L_0, q(PI), 1002);
        one(C_N, L_0, q(PI), 1003);
        chk_cnt(CNT_EN ? 8'd10 : 8'd0, 1);
        for (int i = 0; i < 290; i++) one(C_N, L_GY, ex(PI, 0, 0, 0, 0, 0, 0, 1), 1004);
        one(C_N, L_0, q(PI), 1005);
        one(C_N, L_0, q(PI), 1006);
        chk_cnt(CNT_EN ? 8'd255 : 8'd0, 2);
        one(C_SET, L_0, q(PI), 1007);
        one(C_N, L_0, q(PI), 1008);
        chk_cnt(8'd0, 3);
        one(C_N, L_GY, ex(PI, 0, 0, 0, 0, 0, 0, 1), 1009);
        one(C_N, L_0, q(PI), 1010);
        chk_cnt(CNT_EN ? 8'd1 : 8'd0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
